// File: rtl/tone_pkg.sv
// Shared types and pitch data for the melody player: FSM states, note codes and
// half-period table for a 1 MHz clock.
package tone_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StDone} state_e;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  localparam logic [15:0] PITCH_TABLE [12] = '{
    16'd1911, 16'd1804, 16'd1703, 16'd1607, 16'd1517, 16'd1432,
    16'd1351, 16'd1276, 16'd1204, 16'd1136, 16'd1073, 16'd1012
  };

  // Codes outside 1..12 are silent; the octave shift truncates.
  function automatic logic [15:0] pitch_m(input logic [3:0] code, input logic [1:0] shift);
    logic [15:0] base;
    base = '0;
    if (code >= NOTE_C && code <= NOTE_B) begin
      base = PITCH_TABLE[code - NOTE_C];
    end
    return base >> shift;
  endfunction

endpackage

// File: rtl/melody_player_if.sv
// Control and note-output bundle between the melody player and its driver.
interface melody_player_if;
  logic        mode;
  logic        play;
  logic [7:0]  key;
  logic [1:0]  oct;
  logic [15:0] m;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (output mode, play, key, oct, input m, note_idx, busy, done);
  modport slave  (input mode, play, key, oct, output m, note_idx, busy, done);
endinterface

// File: rtl/song_rom.sv
// Song ROM of {note[7:4], duration[3:0]} bytes with a registered read port.
module song_rom #(
  parameter int unsigned ADDR_W   = 6,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_o
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    data_o <= mem[addr];
  end

endmodule

// File: rtl/melody_player.sv
// Keyboard / autoplay note source feeding the tone divider's half-period input.
// Define MELODY_LOOP_EN to make the end-of-song marker restart the song.
module melody_player
  import tone_pkg::*;
#(
  parameter int unsigned TICK_CYC  = 250000,
  parameter int unsigned GAP_CYC   = 25000,  // 1 <= GAP_CYC < TICK_CYC
  parameter int unsigned ADDR_W    = 6,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            clr,
  melody_player_if.slave  bus_io
);

  localparam int unsigned TickW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_CYC - 1);
  localparam logic [TickW-1:0] GapStart  = TickW'(TICK_CYC - GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [3:0]        units_q, units_d;
  logic [15:0]       m_q, m_d;
  logic [3:0]        note_q, note_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        rom_data;
  logic [1:0]        eff_oct;
  logic [3:0]        kb_code;
  logic [1:0]        kb_shift;

  // ROM is addressed with the next address so data is ready during LOAD.
  song_rom #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .clk   (clk),
    .addr  (addr_d),
    .data_o(rom_data)
  );

  assign eff_oct = (bus_io.oct > 2'd2) ? 2'd2 : bus_io.oct;

  always_comb begin
    kb_code  = NOTE_REST;
    kb_shift = eff_oct;
    priority casez (bus_io.key)
      8'b???????1: kb_code = NOTE_C;
      8'b??????10: kb_code = NOTE_D;
      8'b?????100: kb_code = NOTE_E;
      8'b????1000: kb_code = NOTE_F;
      8'b???10000: kb_code = NOTE_G;
      8'b??100000: kb_code = NOTE_A;
      8'b?1000000: kb_code = NOTE_B;
      8'b10000000: begin
        kb_code  = NOTE_C;
        kb_shift = eff_oct + 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    units_d = units_q;
    m_d     = m_q;
    note_d  = note_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.mode && bus_io.play) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          m_d     = '0;
          note_d  = NOTE_REST;
          state_d = StLoad;
        end else if (!bus_io.mode) begin
          m_d    = pitch_m(kb_code, kb_shift);
          note_d = kb_code;
        end else begin
          m_d    = '0;
          note_d = NOTE_REST;
        end
      end
      StLoad: begin
        if (rom_data[3:0] == 4'd0) begin
`ifdef MELODY_LOOP_EN
          addr_d  = '0;
          state_d = StLoad;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          m_d     = '0;
          note_d  = NOTE_REST;
          state_d = StDone;
`endif
        end else begin
          note_d  = rom_data[7:4];
          m_d     = pitch_m(rom_data[7:4], eff_oct);
          units_d = rom_data[3:0];
          tick_d  = '0;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          units_d = units_q - 4'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // Silence starts GAP_CYC cycles before the end of the last unit.
        if (units_q == 4'd1 && tick_q == GapStart) begin
          m_d     = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (busy_q && !bus_io.mode) begin
      state_d = StIdle;
      addr_d  = '0;
      tick_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      m_d     = '0;
      note_d  = NOTE_REST;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      addr_q  <= '0;
      tick_q  <= '0;
      units_q <= '0;
      m_q     <= '0;
      note_q  <= NOTE_REST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      units_q <= units_d;
      m_q     <= m_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.m        = m_q;
  assign bus_io.note_idx = note_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;

endmodule
